// File: rtl/beeb_bus_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : beeb_bus_sequencer
// Purpose  : Sequences core bus requests onto the BBC Micro (Beeb) bus, at
//            most one access per Phi0 period. Writes are posted into a small
//            FIFO. A read is accepted only once that FIFO has drained, which
//            keeps writes ahead of reads, and it completes on the falling
//            Phi0 edge of its own bus cycle.
// Ports    : clock, reset       - 64 MHz clock, synchronous active-high reset
//            phi0               - Beeb Phi0, already synchronised to clock
//            req_valid/ready    - core request handshake
//            req_addr/we/wdata  - request address, direction, write data
//            rd_valid, rd_data  - one-clock read-return pulse and its data
//            bus_din            - Beeb data bus input
//            beeb_AB/WE/DO      - Beeb address, write enable, write data
//            wbuf_level         - number of posted writes held (0..DEPTH)
// Revision : 1.0 - initial release
// ============================================================================
module beeb_bus_sequencer #(
    parameter int DEPTH = 4             // write-buffer entries, power of two 2..16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        phi0,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    input  logic        req_we,
    input  logic [7:0]  req_wdata,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    input  logic [7:0]  bus_din,
    output logic [15:0] beeb_AB,
    output logic        beeb_WE,
    output logic [7:0]  beeb_DO,
    output logic [4:0]  wbuf_level
);

    localparam int         c_PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] c_DEPTH_LVL = 5'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_phi0_q;
    logic                 r_cycle_start;
    logic [15:0]          r_fifo_addr [DEPTH];
    logic [7:0]           r_fifo_data [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [4:0]           r_level;
    logic                 r_read_pending;
    logic                 r_read_issued;
    logic [15:0]          r_read_addr;
    logic                 r_rd_valid;
    logic [7:0]           r_rd_data;
    logic [15:0]          r_beeb_ab;
    logic                 r_beeb_we;
    logic [7:0]           r_beeb_do;

    logic                 w_cycle_end;
    logic                 w_ready;
    logic                 w_push;
    logic                 w_rd_accept;
    logic                 w_pop;
    logic                 w_rd_done;

    // Falling edge of Phi0 ends a Beeb cycle; the next one starts a clock later.
    assign w_cycle_end = r_phi0_q & ~phi0;

    // Acceptance depends only on registered level/pending state, never on a pop
    // happening in the same clock. Reads additionally wait for an empty FIFO.
    assign w_ready     = ~r_read_pending &
                         (req_we ? (r_level < c_DEPTH_LVL) : (r_level == 5'd0));
    assign w_push      = req_valid & w_ready & req_we;
    assign w_rd_accept = req_valid & w_ready & ~req_we;

    // A write pushed in the same clock as cycle_start is not visible in r_level
    // yet, so it waits for the following cycle_start.
    assign w_pop       = r_cycle_start & (r_level != 5'd0);
    assign w_rd_done   = w_cycle_end & (r_state == S_READ) & r_read_pending;

    // FIFO storage carries no reset: emptiness is defined by pointers/level.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= req_addr;
            r_fifo_data[r_wr_ptr] <= req_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_phi0_q       <= 1'b0;
            r_cycle_start  <= 1'b0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= 5'd0;
            r_read_pending <= 1'b0;
            r_read_issued  <= 1'b0;
            r_read_addr    <= 16'h0000;
            r_rd_valid     <= 1'b0;
            r_rd_data      <= 8'h00;
            r_beeb_ab      <= 16'hFFFF;
            r_beeb_we      <= 1'b0;
            r_beeb_do      <= 8'hFF;
        end else begin
            r_phi0_q      <= phi0;
            r_cycle_start <= w_cycle_end;
            r_rd_valid    <= w_rd_done;

            if (w_rd_done) begin
                r_rd_data <= bus_din;
            end

            // Pointers wrap naturally because DEPTH is a power of two.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 5'd1;
                2'b01:   r_level <= r_level - 5'd1;
                default: r_level <= r_level;
            endcase

            // Accept and completion are mutually exclusive: accept needs
            // pending low, completion needs it high.
            if (w_rd_accept) begin
                r_read_pending <= 1'b1;
                r_read_addr    <= req_addr;
            end else if (w_rd_done) begin
                r_read_pending <= 1'b0;
                r_read_issued  <= 1'b0;
            end

            // Bus state only moves on cycle_start; outputs hold in between.
            if (r_cycle_start) begin
                if (r_level != 5'd0) begin
                    r_state   <= S_WRITE;
                    r_beeb_ab <= r_fifo_addr[r_rd_ptr];
                    r_beeb_do <= r_fifo_data[r_rd_ptr];
                    r_beeb_we <= 1'b1;
                end else if (r_read_pending && !r_read_issued) begin
                    r_state       <= S_READ;
                    r_read_issued <= 1'b1;
                    r_beeb_ab     <= r_read_addr;
                    r_beeb_do     <= 8'hFF;
                    r_beeb_we     <= 1'b0;
                end else begin
                    r_state   <= S_IDLE;
                    r_beeb_ab <= 16'hFFFF;
                    r_beeb_do <= 8'hFF;
                    r_beeb_we <= 1'b0;
                end
            end
        end
    end

    assign req_ready  = w_ready;
    assign rd_valid   = r_rd_valid;
    assign rd_data    = r_rd_data;
    assign beeb_AB    = r_beeb_ab;
    assign beeb_WE    = r_beeb_we;
    assign beeb_DO    = r_beeb_do;
    assign wbuf_level = r_level;

endmodule

`default_nettype wire
